multicycle_shifter: RTL and testbench

MULTICYCLE_SHIFTER -- requirements
Module: multicycle_shifter

---
 rtl/multicycle_shifter.sv | 130 +++++++++++++
 tb/tb_multicycle_shifter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_shifter.sv
// ============================================================================
// Module   : multicycle_shifter
// Purpose  : 32-bit SRL/ROR/ROL unit, one binary-weighted stage per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_shifter #(
  parameter int SKIP_ZERO_STAGES = 0
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] In,
  input  logic [4:0]  Shift,
  input  logic [1:0]  Op,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Out,
  output logic        Busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [1:0] c_OP_SRL  = 2'b00;
  localparam logic [1:0] c_OP_ROR  = 2'b01;
  localparam logic [1:0] c_OP_ROL  = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [2:0]  r_k;
  logic [31:0] r_data;
  logic [4:0]  r_shift;
  logic [1:0]  r_op;

  logic [2:0]  w_stage;
  logic        w_apply;
  logic        w_last;
  logic [4:0]  w_mask_next;
  logic [5:0]  w_amt;
  logic [31:0] w_moved;

  // Stage selection: in skip mode r_shift is the set of bits still to apply.
  generate
    if (SKIP_ZERO_STAGES != 0) begin : g_skip
      logic [2:0] w_low;
      always_comb begin
        w_low = 3'd0;
        for (int i = 4; i >= 0; i--) begin
          if (r_shift[i]) w_low = 3'(i);
        end
      end
      assign w_stage     = w_low;
      assign w_apply     = (r_shift != 5'd0);
      assign w_mask_next = r_shift & ~(5'd1 << w_low);
      assign w_last      = (w_mask_next == 5'd0);
    end else begin : g_full
      assign w_stage     = r_k;
      assign w_apply     = r_shift[r_k];
      assign w_mask_next = r_shift;
      assign w_last      = (r_k == 3'd4);
    end
  endgenerate

  assign w_amt = 6'd1 << w_stage;

  always_comb begin
    w_moved = r_data;
    case (r_op)
      c_OP_SRL: w_moved = r_data >> w_amt;
      c_OP_ROR: w_moved = (r_data >> w_amt) | (r_data << (6'd32 - w_amt));
      c_OP_ROL: w_moved = (r_data << w_amt) | (r_data >> (6'd32 - w_amt));
      default:  w_moved = r_data;
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= c_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (InValid)  w_state_next = c_SHIFT;
      c_SHIFT: if (w_last)   w_state_next = c_DONE;
      c_DONE:  if (OutReady) w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    InReady  = (r_state == c_IDLE);
    OutValid = (r_state == c_DONE);
    Busy     = (r_state != c_IDLE);
    Out      = (r_state == c_DONE) ? r_data : 32'd0;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_data  <= 32'd0;
      r_k     <= 3'd0;
      r_shift <= 5'd0;
      r_op    <= 2'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (InValid) begin
            r_data  <= In;
            r_shift <= Shift;
            r_op    <= Op;
            r_k     <= 3'd0;
          end
        end
        c_SHIFT: begin
          if (w_apply) r_data <= w_moved;
          r_k     <= r_k + 3'd1;
          r_shift <= w_mask_next;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_shifter.sv
// ============================================================================
// Module   : tb_multicycle_shifter
// Purpose  : Scoreboard bench for multicycle_shifter, both stage modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] in_data;
  logic [4:0]  shift;
  logic [1:0]  op;
  logic [1:0]  out_valid;
  logic        out_ready;
  logic [31:0] out0, out1;
  logic [1:0]  busy;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_shifter #(.SKIP_ZERO_STAGES(0)) u_full (
    .Clock(clk), .ResetN(rst_n), .InValid(in_valid[0]), .InReady(in_ready[0]),
    .In(in_data), .Shift(shift), .Op(op), .OutValid(out_valid[0]),
    .OutReady(out_ready), .Out(out0), .Busy(busy[0])
  );

  multicycle_shifter #(.SKIP_ZERO_STAGES(1)) u_skip (
    .Clock(clk), .ResetN(rst_n), .InValid(in_valid[1]), .InReady(in_ready[1]),
    .In(in_data), .Shift(shift), .Op(op), .OutValid(out_valid[1]),
    .OutReady(out_ready), .Out(out1), .Busy(busy[1])
  );

  function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [4:0] s,
                                         input logic [1:0] o);
    logic [63:0] d;
    logic [63:0] t;
    d = {x, x};
    case (o)
      2'b00:   return x >> s;
      2'b01:   begin t = d >> s; return t[31:0];  end
      2'b10:   begin t = d << s; return t[63:32]; end
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dout(input int sel);
    return (sel != 0) ? out1 : out0;
  endfunction

  // Drives one request and returns after its accept edge.
  task automatic issue(input int sel, input logic [31:0] x, input logic [4:0] s,
                       input logic [1:0] o, input bit push);
    exp_t e;
    @(negedge clk);
    in_data = x; shift = s; op = o; in_valid[sel] = 1'b1;
    if (push) begin
      e.res = ref_op(x, s, o);
      e.lat = (sel == 0) ? 5 : (($countones(s) == 0) ? 1 : $countones(s));
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("accept_inready_low", {31'd0, in_ready[sel]}, 32'd0);
    @(negedge clk);
    in_valid[sel] = 1'b0;
  endtask

  // Operands are scrambled every cycle while waiting: they must not matter.
  task automatic wait_result(input int sel);
    int   n;
    bit   got;
    exp_t e;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (out_valid[sel]) got = 1;
      else begin
        in_data = $urandom; shift = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
      end
    end
    chk("result_seen", {31'd0, got}, 32'd1);
    if (q.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("latency", n, e.lat);
      chk("result", dout(sel), e.res);
      chk("busy_in_done", {31'd0, busy[sel]}, 32'd1);
    end
  endtask

  task automatic release_result(input int sel);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_inready", {31'd0, in_ready[sel]}, 32'd1);
    chk("idle_outvalid", {31'd0, out_valid[sel]}, 32'd0);
    chk("idle_out_zero", dout(sel), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input int sel, input logic [31:0] x, input logic [4:0] s,
                        input logic [1:0] o);
    issue(sel, x, s, o, 1'b1);
    wait_result(sel);
    release_result(sel);
  endtask

  initial begin
    logic [31:0] hold;
    bit          spurious;
    rst_n = 1'b0; in_valid = 2'b00; out_ready = 1'b0;
    in_data = 32'hFFFF_FFFF; shift = 5'd3; op = 2'b01;
    #1;
    chk("rst_inready", {30'd0, in_ready}, 32'd3);
    chk("rst_outvalid", {30'd0, out_valid}, 32'd0);
    chk("rst_busy", {30'd0, busy}, 32'd0);
    chk("rst_out0", out0, 32'd0);
    chk("rst_out1", out1, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'h8000_0000, 5'd31, 2'b00);
    run_op(0, 32'h0000_0001, 5'd1,  2'b01);
    run_op(0, 32'h8000_0001, 5'd4,  2'b10);
    run_op(0, 32'hDEAD_BEEF, 5'd7,  2'b11);
    run_op(0, 32'hA5C3_0F96, 5'd0,  2'b00);
    run_op(0, 32'hA5C3_0F96, 5'd0,  2'b10);
    run_op(0, 32'h1234_5678, 5'd16, 2'b01);
    for (int i = 0; i < 6; i++)
      run_op(0, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));

    // Backpressure: result held while a new request waits at the input.
    issue(0, 32'hCAFE_F00D, 5'd13, 2'b10, 1'b1);
    wait_result(0);
    hold = out0;
    @(negedge clk);
    in_data = 32'h0F0F_0001; shift = 5'd5; op = 2'b01; in_valid[0] = 1'b1;
    q.push_back('{res: ref_op(32'h0F0F_0001, 5'd5, 2'b01), lat: 5});
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_out_stable", out0, hold);
      chk("bp_outvalid", {31'd0, out_valid[0]}, 32'd1);
      chk("bp_no_accept", {31'd0, in_ready[0]}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {31'd0, in_ready[0]}, 32'd1);
    chk("bp_release_outvalid", {31'd0, out_valid[0]}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_new_accepted", {31'd0, busy[0]}, 32'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_result(0);
    release_result(0);

    // Reset two edges into an operation discards it without a clock edge.
    issue(0, 32'h8765_4321, 5'd9, 2'b00, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_inready", {31'd0, in_ready[0]}, 32'd1);
    chk("midrst_outvalid", {31'd0, out_valid[0]}, 32'd0);
    chk("midrst_out", out0, 32'd0);
    chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid[0] || busy[0]) spurious = 1;
    end
    chk("midrst_no_result", {31'd0, spurious}, 32'd0);
    run_op(0, 32'h0000_00F0, 5'd4, 2'b00);

    run_op(1, 32'hFFFF_FFFF, 5'h11, 2'b00);
    run_op(1, 32'h1357_9BDF, 5'd0,  2'b01);
    run_op(1, 32'h8000_0001, 5'd4,  2'b10);
    run_op(1, 32'hDEAD_BEEF, 5'd31, 2'b11);
    for (int i = 0; i < 4; i++)
      run_op(1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
